// File: rtl/alu_op_issue.sv
// alu_op_issue: decodes LEGv8 R-type opcodes into ALU control codes. Each
// decoded operation is held in a main register plus a one-entry skid
// register, so the input-ready handshake is registered and never depends
// combinationally on out_ready.
`timescale 1ns/1ps
module alu_op_issue #(
    parameter  int unsigned BITS  = 64,
    localparam int unsigned OPC_W = 11,
    localparam int unsigned CTL_W = 3,
    localparam int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPC_W-1:0] in_opcode,
    input  logic [BITS-1:0]  in_A,
    input  logic [BITS-1:0]  in_B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BITS-1:0]  out_A,
    output logic [BITS-1:0]  out_B,
    output logic [CTL_W-1:0] out_cntrl,
    output logic             out_orBit,
    output logic             out_illegal,
    output logic [CNT_W-1:0] issue_count
);

    localparam logic [OPC_W-1:0] OP_ADD = 11'b10001011000;
    localparam logic [OPC_W-1:0] OP_SUB = 11'b11001011000;
    localparam logic [OPC_W-1:0] OP_AND = 11'b10001010000;
    localparam logic [OPC_W-1:0] OP_ORR = 11'b10101010000;
    localparam logic [OPC_W-1:0] OP_EOR = 11'b11001010000;

    localparam logic [CTL_W-1:0] CTL_PASSB = 3'b000;
    localparam logic [CTL_W-1:0] CTL_ADD   = 3'b010;
    localparam logic [CTL_W-1:0] CTL_SUB   = 3'b011;
    localparam logic [CTL_W-1:0] CTL_AND   = 3'b100;
    localparam logic [CTL_W-1:0] CTL_ORR   = 3'b101;
    localparam logic [CTL_W-1:0] CTL_EOR   = 3'b110;

    // Decoded operation as it travels through the buffers.
    typedef struct packed {
        logic [BITS-1:0]  a;
        logic [BITS-1:0]  b;
        logic [CTL_W-1:0] cntrl;
        logic             illegal;
    } op_t;

    op_t              main_q, main_d;
    op_t              skid_q, skid_d;
    logic             main_valid_q, main_valid_d;
    logic             skid_full_q, skid_full_d;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             accept_c;
    logic             drain_c;
    logic [CTL_W-1:0] dec_cntrl_c;
    logic             dec_illegal_c;
    op_t              in_op_c;

    // Opcode decode, evaluated at acceptance time only.
    always_comb begin
        dec_cntrl_c   = CTL_PASSB;
        dec_illegal_c = 1'b0;
        case (in_opcode)
            OP_ADD:  dec_cntrl_c = CTL_ADD;
            OP_SUB:  dec_cntrl_c = CTL_SUB;
            OP_AND:  dec_cntrl_c = CTL_AND;
            OP_ORR:  dec_cntrl_c = CTL_ORR;
            OP_EOR:  dec_cntrl_c = CTL_EOR;
            default: dec_illegal_c = 1'b1;
        endcase
    end

    // Next-state for main/skid buffers, ready flag and transfer counter.
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_full_d  = skid_full_q;
        cnt_d        = cnt_q;

        accept_c = in_valid & in_ready_q;
        drain_c  = main_valid_q & out_ready;

        in_op_c.a       = in_A;
        in_op_c.b       = in_B;
        in_op_c.cntrl   = dec_cntrl_c;
        in_op_c.illegal = dec_illegal_c;

        if (drain_c) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (skid_full_q) begin
                // in_ready is low whenever skid is full, so nothing new arrives here.
                main_d      = skid_q;
                skid_full_d = 1'b0;
            end else if (accept_c) begin
                main_d = in_op_c;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept_c) begin
            if (!main_valid_q) begin
                main_d       = in_op_c;
                main_valid_d = 1'b1;
            end else begin
                skid_d      = in_op_c;
                skid_full_d = 1'b1;
            end
        end

        in_ready_d = ~skid_full_d;
    end

    // State registers; in_ready stays low through reset and rises on the first edge after.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_full_q  <= 1'b0;
            in_ready_q   <= 1'b0;
            cnt_q        <= '0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_full_q  <= skid_full_d;
            in_ready_q   <= in_ready_d;
            cnt_q        <= cnt_d;
        end
    end

    // Outputs come straight from registered state.
    assign in_ready    = in_ready_q;
    assign out_valid   = main_valid_q;
    assign out_A       = main_q.a;
    assign out_B       = main_q.b;
    assign out_cntrl   = main_q.cntrl;
    assign out_orBit   = main_q.cntrl[0];
    assign out_illegal = main_q.illegal;
    assign issue_count = cnt_q;

endmodule

// File: tb/tb_alu_op_issue.sv
// tb_alu_op_issue: scoreboard bench for alu_op_issue. Expected operations are
// queued when the input handshake is seen and compared when the output fires.
`timescale 1ns/1ps
module tb_alu_op_issue;

    localparam int unsigned BITS = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [10:0]     in_opcode;
    logic [BITS-1:0] in_A;
    logic [BITS-1:0] in_B;
    logic            out_valid;
    logic            out_ready;
    logic [BITS-1:0] out_A;
    logic [BITS-1:0] out_B;
    logic [2:0]      out_cntrl;
    logic            out_orBit;
    logic            out_illegal;
    logic [15:0]     issue_count;

    typedef struct packed {
        logic [BITS-1:0] a;
        logic [BITS-1:0] b;
        logic [2:0]      cntrl;
        logic            orbit;
        logic            illegal;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_cnt  = 0;
    int   run_len  = 0;
    int   max_run  = 0;

    logic [10:0] opc_tab [6] = '{11'b10001011000, 11'b11001011000, 11'b10001010000,
                                 11'b10101010000, 11'b11001010000, 11'b11111111111};
    logic [2:0]  ctl_tab [5] = '{3'b010, 3'b011, 3'b100, 3'b101, 3'b110};
    logic        orb_tab [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    always #5 clk = ~clk;

    alu_op_issue #(.BITS(BITS)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_opcode   (in_opcode),
        .in_A        (in_A),
        .in_B        (in_B),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_A       (out_A),
        .out_B       (out_B),
        .out_cntrl   (out_cntrl),
        .out_orBit   (out_orBit),
        .out_illegal (out_illegal),
        .issue_count (issue_count)
    );

    task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [10:0] op, input logic [BITS-1:0] a,
                                   input logic [BITS-1:0] b);
        exp_t e;
        e.a       = a;
        e.b       = b;
        e.illegal = 1'b0;
        case (op)
            11'b10001011000: begin e.cntrl = 3'b010; e.orbit = 1'b0; end
            11'b11001011000: begin e.cntrl = 3'b011; e.orbit = 1'b1; end
            11'b10001010000: begin e.cntrl = 3'b100; e.orbit = 1'b0; end
            11'b10101010000: begin e.cntrl = 3'b101; e.orbit = 1'b1; end
            11'b11001010000: begin e.cntrl = 3'b110; e.orbit = 1'b0; end
            default:         begin e.cntrl = 3'b000; e.orbit = 1'b0; e.illegal = 1'b1; end
        endcase
        return e;
    endfunction

    // Output monitor: inputs only change just after posedge, so negedge sees the transfer-to-be.
    always @(negedge clk) begin
        if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 256'(sb.size()), 256'(1));
            end else begin
                mon_e = sb.pop_front();
                check("payload", 256'({out_A, out_B, out_cntrl, out_orBit, out_illegal}), 256'(mon_e));
            end
            exp_cnt = (exp_cnt + 1) % 65536;
            run_len++;
            if (run_len > max_run) max_run = run_len;
        end else begin
            run_len = 0;
        end
    end

    // Offer one op; called just after a posedge, returns just after the accepting posedge.
    task automatic push(input logic [10:0] op, input logic [BITS-1:0] a, input logic [BITS-1:0] b);
        bit done = 1'b0;
        in_opcode = op;
        in_A      = a;
        in_B      = b;
        in_valid  = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                sb.push_back(model(op, a, b));
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) check("push_timeout", 256'(0), 256'(1));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BITS-1:0] sa;
        logic [BITS-1:0] sbv;
        int              need;

        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_opcode = '0;
        in_A      = '0;
        in_B      = '0;

        // Reset state, including across a clock edge while held.
        #3;
        check("rst_outs", 256'({out_valid, in_ready, out_A, out_B, out_cntrl, out_orBit, out_illegal}), 256'(0));
        check("rst_count", 256'(issue_count), 256'(0));
        #10;
        check("rst_hold", 256'({out_valid, in_ready, issue_count}), 256'(0));

        // Release between edges with an offer pending; first edge only raises in_ready.
        #9;
        in_opcode = 11'b10001011000;
        in_A      = 64'd1;
        in_B      = 64'd2;
        in_valid  = 1'b1;
        reset     = 1'b1;
        #1;
        check("post_rst_ready_low", 256'(in_ready), 256'(0));
        @(posedge clk);
        #1;
        check("post_rst_ready_high", 256'(in_ready), 256'(1));
        check("post_rst_no_xfer", 256'(out_valid), 256'(0));
        in_valid = 1'b0;

        // Backpressure: two ops fill main and skid, the third waits for a drain.
        out_ready = 1'b0;
        push(11'b10001011000, 64'hA1, 64'hB1);
        check("bp_first_valid", 256'(out_valid), 256'(1));
        check("bp_ready_after_1", 256'(in_ready), 256'(1));
        push(11'b11001011000, 64'hA2, 64'hB2);
        check("bp_ready_after_2", 256'(in_ready), 256'(0));
        in_opcode = 11'b10001010000;
        in_A      = 64'hA3;
        in_B      = 64'hB3;
        in_valid  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            idle(1);
            check("bp_stable_A", 256'(out_A), 256'(64'hA1));
            check("bp_stable_ctl", 256'(out_cntrl), 256'(3'b010));
            check("bp_hold_ready", 256'({out_valid, in_ready}), 256'(2'b10));
        end
        out_ready = 1'b1;
        push(11'b10001010000, 64'hA3, 64'hB3);
        idle(2);
        check("bp_count", 256'(issue_count), 256'(3));
        check("bp_sb_empty", 256'(sb.size()), 256'(0));

        // Decode sweep with one-cycle latency from an empty main register.
        for (int i = 0; i < 5; i++) begin
            push(opc_tab[i], 64'hF0F0_F0F0_F0F0_F0F0, 64'h0FF0_0FF0_0FF0_0F0F);
            check("dec_latency", 256'(out_valid), 256'(1));
            check("dec_cntrl", 256'(out_cntrl), 256'(ctl_tab[i]));
            check("dec_orbit", 256'(out_orBit), 256'(orb_tab[i]));
            check("dec_illegal", 256'(out_illegal), 256'(0));
            idle(1);
        end

        // Unrecognised opcode passes B and flags illegal.
        push(11'b11111111111, 64'hF0F0_F0F0_F0F0_F0F0, 64'h1234);
        check("ill_cntrl", 256'(out_cntrl), 256'(3'b000));
        check("ill_flag", 256'(out_illegal), 256'(1));
        check("ill_B", 256'(out_B), 256'(64'h1234));
        idle(2);
        check("drain_valid_fall", 256'(out_valid), 256'(0));

        // Streaming: 100 back-to-back ops must leave in 100 consecutive cycles.
        max_run = 0;
        for (int i = 0; i < 100; i++) begin
            sa  = {$urandom, $urandom};
            sbv = {$urandom, $urandom};
            push(opc_tab[$urandom_range(0, 5)], sa, sbv);
        end
        idle(3);
        check("stream_run", 256'(max_run), 256'(100));
        check("stream_count", 256'(issue_count), 256'(exp_cnt));
        check("stream_count_abs", 256'(issue_count), 256'(3 + 5 + 1 + 100));

        // Asynchronous reset with main and skid both full.
        out_ready = 1'b0;
        push(11'b10101010000, 64'h11, 64'h22);
        push(11'b11001010000, 64'h33, 64'h44);
        check("mid_full", 256'({out_valid, in_ready}), 256'(2'b10));
        #3;
        reset = 1'b0;
        #1;
        check("mid_rst_valid", 256'(out_valid), 256'(0));
        check("mid_rst_ready", 256'(in_ready), 256'(0));
        check("mid_rst_count", 256'(issue_count), 256'(0));
        check("mid_rst_A", 256'(out_A), 256'(0));
        sb.delete();
        exp_cnt = 0;
        #2;
        reset     = 1'b1;
        out_ready = 1'b1;
        #1;
        check("mid_rel_ready_low", 256'(in_ready), 256'(0));
        @(posedge clk);
        #1;
        check("mid_rel_ready_high", 256'(in_ready), 256'(1));
        check("mid_rel_no_valid", 256'(out_valid), 256'(0));

        // Counter wrap: 65535 transfers then one more.
        need = 65535 - exp_cnt;
        for (int i = 0; i < need; i++) begin
            sa  = {$urandom, $urandom};
            sbv = {$urandom, $urandom};
            push(opc_tab[i % 6], sa, sbv);
        end
        idle(2);
        check("wrap_pre", 256'(issue_count), 256'(16'hFFFF));
        push(11'b10001011000, 64'h5, 64'h6);
        idle(2);
        check("wrap_post", 256'(issue_count), 256'(16'h0000));
        check("final_sb_empty", 256'(sb.size()), 256'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_op_issue.md
ALU_OP_ISSUE -- requirements
Module: alu_op_issue

Interface
REQ-001 Parameter BITS, default 64, operand width.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low; asserted (0) clears all state immediately, independent of clk.
REQ-004 in_valid  input  1  upstream has an instruction this cycle.
REQ-005 in_ready  output  1  block can accept; transfer when in_valid & in_ready at rising edge.
REQ-006 in_opcode  input  11  LEGv8 R-type opcode field.
REQ-007 in_A, in_B  input  BITS each  operands.
REQ-008 out_valid  output  1  issue slot holds a valid operation.
REQ-009 out_ready  input  1  ALU/execute stage accepts; transfer when out_valid & out_ready at rising edge.
REQ-010 out_A, out_B  output  BITS each  operands for the ALU.
REQ-011 out_cntrl  output  3  ALU control code.
REQ-012 out_orBit  output  1  select for the bitwise AND/OR unit; equals out_cntrl[0].
REQ-013 out_illegal  output  1  issued op had an unrecognised opcode.
REQ-014 issue_count  output  16  number of completed output transfers.

Function
REQ-015 The block SHALL decode opcodes as: 10001011000 ADD -> 010; 11001011000 SUB -> 011; 10001010000 AND -> 100; 10101010000 ORR -> 101; 11001010000 EOR -> 110; any other -> 000 (pass B) with out_illegal=1.
REQ-016 Decode SHALL occur at input acceptance; decoded cntrl/illegal are stored with the operands, never recomputed at output.
REQ-017 Storage SHALL be a main register (drives outputs) plus a one-entry skid register; FIFO order preserved.
REQ-018 in_ready SHALL be registered and equal to NOT skid_full; it SHALL NOT depend combinationally on out_ready.
REQ-019 Latency: an input accepted at edge N with main empty SHALL appear on outputs with out_valid=1 after edge N (one cycle).
REQ-020 Throughput: with out_ready held 1, one operation per cycle SHALL pass with no bubbles.
REQ-021 Main empty, or main draining this edge with skid empty: accepted input SHALL load main.
REQ-022 Main full and not draining: accepted input SHALL load skid; in_ready falls next cycle.
REQ-023 Main drains while skid full: skid SHALL move to main; skid empties; in_ready rises next cycle; no input accepted that edge.
REQ-024 Main drains, skid empty, no input: out_valid SHALL fall next cycle.
REQ-025 Output fields SHALL be stable while out_valid=1 and out_ready=0.
REQ-026 issue_count SHALL increment by 1 on each output transfer and wrap 0xFFFF -> 0x0000.
REQ-027 When out_valid=0, out_A/out_B/out_cntrl/out_orBit/out_illegal are don't-care but SHALL hold last value (no X).

Reset
REQ-028 While reset=0: out_valid=0, in_ready=0, skid empty, out_A=out_B=0, out_cntrl=000, out_orBit=0, out_illegal=0, issue_count=0.
REQ-029 First rising clk edge after reset deasserts SHALL set in_ready=1; no transfer SHALL occur on that edge.
REQ-030 Reset asserted mid-operation SHALL discard both buffered entries; no partial output transfer counted.

Verification
REQ-031 Decode sweep: each of ADD/SUB/AND/ORR/EOR with A=0xF0F0..F0, B=0x0FF0..0F, out_ready=1 -> out_cntrl 010/011/100/101/110, out_orBit 0/1/0/1/0, illegal 0, outputs one cycle later.
REQ-032 Illegal: opcode 11111111111, B=0x1234 -> out_cntrl=000, out_illegal=1, out_B=0x1234.
REQ-033 Backpressure: out_ready=0, push three ops -> first two accepted, in_ready=0 after second; raise out_ready -> ops exit in order, third accepted after one drain, issue_count=3.
REQ-034 Streaming: 100 back-to-back ops, out_ready=1 -> 100 transfers in 100 consecutive cycles, issue_count=100.
REQ-035 Wrap: preload 65535 transfers, issue one more -> issue_count=0x0000.
REQ-036 Reset mid-flight: main and skid full, pulse reset low asynchronously between edges -> out_valid=0, in_ready=0, issue_count=0 immediately; in_ready=1 after first post-reset edge.
